// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator display codes and converter state encoding
//
// Purpose: constants shared by the BCD converter and the seven-segment encoder.
// Ports: none (package).
package calc_pkg;

    // Display codes above the decimal range, understood by the seven-seg encoder.
    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_ERR   = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction (+3 when digit >= 5)
//
// Purpose: pre-shift correction for one BCD digit so the following left
//          shift carries correctly into the next decimal digit.
// Ports:
//   din  - current BCD digit
//   dout - corrected digit (din + 3 when din >= 5, else din)
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// rtl/result_bcd_converter.sv - iterative binary-to-BCD converter with display formatting
//
// Purpose: converts the calculator's unsigned result magnitude into display
//          codes one bit per clock (double dabble), then applies sign, error
//          and overflow formatting for the 4-digit display mux.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   start    - conversion request, sampled only when idle
//   value    - unsigned magnitude to convert
//   neg      - magnitude represents a negative result
//   error    - result is invalid
//   busy     - conversion in progress
//   done     - one-cycle pulse when digits/overflow are updated
//   digits   - display codes, [3:0] = ones digit
//   overflow - last result could not be shown in the available digits
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       value,
    input  logic                  neg,
    input  logic                  error,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow
);

    // One spare BCD digit catches magnitudes beyond the display width.
    localparam int BW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(IN_W + 1);

    conv_state_t state, state_next;

    logic [IN_W-1:0]     shreg;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt;
    logic                neg_q;
    logic                err_q;

    logic                load;
    logic                shift_en;
    logic                fmt_en;

    logic [4*DIGITS-1:0] fmt_digits;
    logic                fmt_ovf;

    // The top corrected digit never carries out for legal input widths.
    logic                unused_adj_msb;
    assign unused_adj_msb = bcd_adj[BW-1];

    for (genvar gi = 0; gi <= DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd[4*gi +: 4]),
            .dout (bcd_adj[4*gi +: 4])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. SHIFT spends one extra cycle at terminal count so
    // the result lands a fixed IN_W+2 edges after start is sampled. A start
    // arriving while the done pulse is up is dropped rather than accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !done) state_next = SHIFT;
            SHIFT:   if (cnt == '0)      state_next = FORMAT;
            FORMAT:                      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Datapath controls
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        fmt_en   = 1'b0;
        case (state)
            IDLE:    load     = start && !done;
            SHIFT:   shift_en = (cnt != '0);
            FORMAT:  fmt_en   = 1'b1;
            default: ;
        endcase
    end

    // Result formatting from latched flags and the final BCD accumulator.
    always_comb begin
        fmt_ovf    = 1'b0;
        fmt_digits = bcd[4*DIGITS-1:0];
        if (err_q) begin
            fmt_digits = {DIGITS{CODE_ERR}};
        end else if (bcd[BW-1 -: 4] != 4'd0) begin
            fmt_digits = {DIGITS{CODE_ERR}};
            fmt_ovf    = 1'b1;
        end else if (neg_q && (bcd[4*DIGITS-1:8] != '0)) begin
            // Negative values only have two digit positions after the minus.
            fmt_digits = {DIGITS{CODE_ERR}};
            fmt_ovf    = 1'b1;
        end else if (neg_q) begin
            for (int i = 2; i < DIGITS; i++) begin
                fmt_digits[4*i +: 4] = (i == 2) ? CODE_MINUS : CODE_BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= fmt_en;
            busy <= (state == SHIFT);
            if (load) begin
                shreg <= value;
                neg_q <= neg;
                err_q <= error;
                bcd   <= '0;
                cnt   <= CW'(IN_W);
            end else if (shift_en) begin
                bcd   <= {bcd_adj[BW-2:0], shreg[IN_W-1]};
                shreg <= {shreg[IN_W-2:0], 1'b0};
                cnt   <= cnt - CW'(1);
            end
            if (fmt_en) begin
                digits   <= fmt_digits;
                overflow <= fmt_ovf;
            end
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// tb/tb_result_bcd_converter.sv - scoreboard bench for result_bcd_converter
module tb_result_bcd_converter;

    localparam int IN_W   = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = IN_W + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        neg = 1'b0;
    logic        error = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic        overflow;

    always #5 clk = ~clk;

    result_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .neg      (neg),
        .error    (error),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
        int          s;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   armed    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Display formatting computed directly from the decimal value.
    function automatic logic [16:0] ref_model(input int v, input bit n, input bit e);
        int th, hu, te, on;
        th = (v / 1000) % 10;
        hu = (v / 100) % 10;
        te = (v / 10) % 10;
        on = v % 10;
        if (e)              return {1'b0, 16'hBBBB};
        if (v > 9999)       return {1'b1, 16'hBBBB};
        if (n && v > 99)    return {1'b1, 16'hBBBB};
        if (n)              return {1'b0, 4'hC, 4'hA, te[3:0], on[3:0]};
        return {1'b0, th[3:0], hu[3:0], te[3:0], on[3:0]};
    endfunction

    // Called at posedge+#1; drives one start cycle then scrambles inputs.
    task automatic issue(input int v, input bit n, input bit e, input bit push, output int due);
        logic [16:0] r;
        exp_t x;
        r     = ref_model(v, n, e);
        start = 1'b1;
        value = v[13:0];
        neg   = n;
        error = e;
        @(posedge clk); #1;
        due = cyc + LAT;
        if (push) begin
            x.dig = r[15:0];
            x.ovf = r[16];
            x.s   = cyc;
            x.due = due;
            q.push_back(x);
        end
        start = 1'b0;
        value = 14'($urandom);
        neg   = 1'($urandom);
        error = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            check("wait_idle_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic run(input int v, input bit n, input bit e);
        int d;
        issue(v, n, e, 1'b1, d);
        wait_idle();
    endtask

    // Monitor: busy/done/digits checked every cycle against the scoreboard.
    initial begin
        exp_t        e;
        logic [15:0] hold_dig;
        logic        hold_ovf;
        bit          rst_prev;
        bit          exp_busy;
        hold_dig = '0;
        hold_ovf = 1'b0;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                hold_dig = '0;
                hold_ovf = 1'b0;
            end
            rst_prev = rst;
            if (armed) begin
                exp_busy = (q.size() != 0) && (cyc > q[0].s) && (cyc < q[0].due);
                check("busy", busy, exp_busy);
                if (done) begin
                    if (q.size() == 0) begin
                        check("spurious_done", done, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check("latency", 32'(cyc - e.s), 32'(LAT));
                        check("digits", digits, e.dig);
                        check("overflow", overflow, e.ovf);
                        hold_dig = e.dig;
                        hold_ovf = e.ovf;
                    end
                end else begin
                    check("digits_hold", digits, hold_dig);
                    check("overflow_hold", overflow, hold_ovf);
                    if (q.size() != 0 && cyc >= q[0].due) begin
                        check("done_timeout", done, 1'b1);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 5000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_digits", digits, 16'h0000);
        check("reset_overflow", overflow, 1'b0);
        armed = 1'b1;

        // Directed values and formatting boundaries
        run(1234, 1'b0, 1'b0);
        run(0, 1'b0, 1'b0);
        run(9999, 1'b0, 1'b0);
        run(10000, 1'b0, 1'b0);
        run(45, 1'b1, 1'b0);
        run(120, 1'b1, 1'b0);
        run(99, 1'b1, 1'b0);
        run(77, 1'b0, 1'b1);
        run(16383, 1'b0, 1'b0);

        // Start while busy is dropped; start on the done cycle is dropped;
        // start the following cycle is accepted.
        issue(1234, 1'b0, 1'b0, 1'b1, d);
        repeat (4) begin @(posedge clk); #1; end
        issue(5678, 1'b0, 1'b0, 1'b0, v);
        for (int i = 0; i < 40 && cyc < d; i++) begin @(posedge clk); #1; end
        issue(1111, 1'b0, 1'b0, 1'b0, v);
        issue(5678, 1'b0, 1'b0, 1'b1, v);
        wait_idle();

        // Reset mid-conversion discards the result
        issue(4321, 1'b0, 1'b0, 1'b1, d);
        repeat (7) begin @(posedge clk); #1; end
        do_reset();
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_digits", digits, 16'h0000);
        check("midrst_overflow", overflow, 1'b0);
        repeat (20) begin @(posedge clk); #1; end
        run(2468, 1'b0, 1'b0);

        // Randomized conversions with occasional boundary values
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       v = 9999;
                1:       v = 10000;
                2:       v = 99 + int'($urandom_range(0, 1));
                default: v = int'($urandom_range(0, 16383));
            endcase
            issue(v, 1'($urandom), ($urandom_range(0, 7) == 0), 1'b1, d);
            wait_idle();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
